// File: rtl/mult_booth_seq_if.sv
// Handshake and result bundle for the sequential Booth multiplier.
// The master drives the start/operand side; the slave is the multiplier itself.
interface mult_booth_seq_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     operand_a;
    logic [WIDTH-1:0]     operand_b;
    logic                 busy;
    logic                 result_rdy;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     result;
    logic                 overflow;

    modport master (
        output start, operand_a, operand_b,
        input  busy, result_rdy, product, result, overflow
    );

    modport slave (
        input  start, operand_a, operand_b,
        output busy, result_rdy, product, result, overflow
    );
endinterface

// File: rtl/mult_booth_seq.sv
// Sequential radix-4 (modified Booth) signed multiplier, two multiplier bits per cycle.
// Full 2*WIDTH product, low word and overflow are registered on entry to DONE and held.
module mult_booth_seq #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              clr,
    mult_booth_seq_if.slave   bus
);
    localparam int PW = 2 * WIDTH + 1;
    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH / 2) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [WIDTH-1:0]      r_a;
    logic [PW-1:0]         r_p;
    logic [CW-1:0]         r_cnt;
    logic [2*WIDTH-1:0]    r_product;
    logic                  r_overflow;

    logic                  w_busy;
    logic                  w_rdy;
    logic                  w_start_ok;
    logic                  w_last;
    logic [AW-1:0]         w_acc_ext;
    logic [AW-1:0]         w_a1;
    logic [AW-1:0]         w_a2;
    logic [AW-1:0]         w_addend;
    logic [AW-1:0]         w_sum;
    logic [PW-1:0]         w_p_next;
    logic [2*WIDTH-1:0]    w_prod_final;
    logic [WIDTH:0]        w_hi;
    logic                  w_ovf_final;

    assign w_start_ok = bus.start && (r_state != S_RUN);
    assign w_last     = (r_cnt == CW'(WIDTH / 2 - 1));

    // Two guard bits on the accumulator keep +/-2A of the most negative A exact
    assign w_acc_ext = {{2{r_p[PW-1]}}, r_p[PW-1:WIDTH+1]};
    assign w_a1      = {{2{r_a[WIDTH-1]}}, r_a};
    assign w_a2      = {r_a[WIDTH-1], r_a, 1'b0};

    always_comb begin
        w_addend = '0;
        case (r_p[2:0])
            3'b001, 3'b010: w_addend = w_a1;
            3'b011:         w_addend = w_a2;
            3'b100:         w_addend = -w_a2;
            3'b101, 3'b110: w_addend = -w_a1;
            default:        w_addend = '0;
        endcase
    end

    // Arithmetic shift right by two: the sum's sign bits flow down into the upper word
    assign w_sum        = w_acc_ext + w_addend;
    assign w_p_next     = {w_sum, r_p[WIDTH:2]};
    assign w_prod_final = {w_sum, r_p[WIDTH:3]};
    assign w_hi         = w_prod_final[2*WIDTH-1:WIDTH-1];
    assign w_ovf_final  = (|w_hi) && !(&w_hi);

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_rdy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_next = S_RUN;
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                w_rdy        = 1'b1;
                w_state_next = bus.start ? S_RUN : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_p        <= '0;
            r_cnt      <= '0;
            r_product  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start_ok) begin
                r_a   <= bus.operand_a;
                r_p   <= {{WIDTH{1'b0}}, bus.operand_b, 1'b0};
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_p   <= w_p_next;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_product  <= w_prod_final;
                    r_overflow <= w_ovf_final;
                end
            end
        end
    end

    assign bus.busy       = w_busy;
    assign bus.result_rdy = w_rdy;
    assign bus.product    = r_product;
    assign bus.result     = r_product[WIDTH-1:0];
    assign bus.overflow   = r_overflow;
endmodule
